// File: rtl/ro_puf_engine.sv
// Measurement and response engine for the weak RO-PUF.
// Launches N_EVAL count windows. After each window it walks the RO pairs one per
// cycle, accumulating a majority vote and a stability flag per pair. When all
// windows are done it resolves the response bits and the reliable-pair mask.
module ro_puf_engine #(
   parameter int unsigned N_RO      = 128,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned WINDOW    = 50000,
   parameter int unsigned N_EVAL    = 5,
   parameter int unsigned THRESH    = 16,
   parameter int unsigned PAIR_MODE = 0,
   parameter int unsigned TIMEOUT   = 131072
) (
   input  logic                    clk_ref,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic                    cnt_start,
   output logic [31:0]             cnt_window,
   input  logic                    cnt_done,
   input  logic [N_RO*CNT_W-1:0]   counts,
   output logic [N_RO/2-1:0]       puf_response,
   output logic [N_RO/2-1:0]       stable_mask,
   output logic                    resp_valid
);

   localparam int unsigned N_PAIR = N_RO / 2;
   localparam int unsigned PAIR_W = $clog2(N_PAIR);
   localparam int unsigned IDX_W  = $clog2(N_RO);
   localparam int unsigned EVAL_W = $clog2(N_EVAL + 1);
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEASURE,
      S_COMPARE,
      S_RESOLVE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t              state;
   state_t              state_nx;

   logic [WAIT_W-1:0]   wait_cnt;
   logic [PAIR_W-1:0]   pair_idx;
   logic [EVAL_W-1:0]   eval_idx;

   logic [EVAL_W-1:0]   vote [N_PAIR];
   logic [N_PAIR-1:0]   ref_bit;
   logic [N_PAIR-1:0]   unstable;

   logic                start_acc;
   logic                meas_done;
   logic                last_pair;
   logic                last_eval;

   logic [IDX_W-1:0]    a_idx;
   logic [IDX_W-1:0]    b_idx;
   logic [CNT_W-1:0]    cnt_a;
   logic [CNT_W-1:0]    cnt_b;
   logic [CNT_W:0]      diff;
   logic                cmp_bit;
   logic                near;

   // The count window length is a fixed configuration value.
   assign cnt_window = 32'(WINDOW);

   // Handshake strobes and loop-end flags shared by the FSM and the datapath.
   always_comb begin
      start_acc = 1'b0;
      meas_done = 1'b0;
      last_pair = (pair_idx == PAIR_W'(N_PAIR - 1));
      last_eval = (eval_idx == EVAL_W'(N_EVAL - 1));
      if (state == S_IDLE) begin
         start_acc = start;
      end
      // cnt_done is only trusted from the cycle after the launch pulse.
      if (state == S_MEASURE) begin
         meas_done = cnt_done & ~cnt_start;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start_acc) begin
               state_nx = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (meas_done) begin
               state_nx = S_COMPARE;
            end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
               state_nx = S_ERROR;
            end
         end
         S_COMPARE: begin
            if (last_pair) begin
               state_nx = last_eval ? S_RESOLVE : S_MEASURE;
            end
         end
         S_RESOLVE: state_nx = S_DONE;
         S_DONE:    state_nx = S_IDLE;
         S_ERROR:   state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Window wait counter, pair walker and window index.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         pair_idx <= '0;
         eval_idx <= '0;
      end else begin
         wait_cnt <= (state == S_MEASURE) ? wait_cnt + WAIT_W'(1) : '0;
         pair_idx <= (state == S_COMPARE && !last_pair) ? pair_idx + PAIR_W'(1) : '0;
         if (start_acc) begin
            eval_idx <= '0;
         end else if (state == S_COMPARE && last_pair && !last_eval) begin
            eval_idx <= eval_idx + EVAL_W'(1);
         end
      end
   end

   // Select the two counts of the current pair and compare them without wraparound.
   always_comb begin
      if (PAIR_MODE != 0) begin
         a_idx = IDX_W'({pair_idx, 1'b0});
         b_idx = IDX_W'({pair_idx, 1'b1});
      end else begin
         a_idx = IDX_W'(pair_idx);
         b_idx = IDX_W'(pair_idx) + IDX_W'(N_PAIR);
      end
      cnt_a   = counts[32'(a_idx) * CNT_W +: CNT_W];
      cnt_b   = counts[32'(b_idx) * CNT_W +: CNT_W];
      cmp_bit = (cnt_a > cnt_b);
      diff    = cmp_bit ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                        : ({1'b0, cnt_b} - {1'b0, cnt_a});
      near    = (diff < (CNT_W + 1)'(THRESH));
   end

   // Per-pair vote and stability accumulation, then resolution into the outputs.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(N_PAIR); i++) begin
            vote[i] <= '0;
         end
         ref_bit      <= '0;
         unstable     <= '0;
         puf_response <= '0;
         stable_mask  <= '0;
      end else if (start_acc) begin
         for (int i = 0; i < int'(N_PAIR); i++) begin
            vote[i] <= '0;
         end
         ref_bit  <= '0;
         unstable <= '0;
      end else if (state == S_COMPARE) begin
         if (cmp_bit && vote[pair_idx] != EVAL_W'(N_EVAL)) begin
            vote[pair_idx] <= vote[pair_idx] + EVAL_W'(1);
         end
         if (eval_idx == '0) begin
            ref_bit[pair_idx]  <= cmp_bit;
            unstable[pair_idx] <= unstable[pair_idx] | near;
         end else begin
            unstable[pair_idx] <= unstable[pair_idx] | near | (cmp_bit != ref_bit[pair_idx]);
         end
      end else if (state == S_RESOLVE) begin
         for (int i = 0; i < int'(N_PAIR); i++) begin
            puf_response[i] <= (vote[i] > EVAL_W'(N_EVAL / 2));
            stable_mask[i]  <= ~unstable[i] &
                               ((vote[i] == '0) | (vote[i] == EVAL_W'(N_EVAL)));
         end
      end
   end

   // Registered status and handshake outputs, derived from the upcoming state.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         resp_valid <= 1'b0;
         cnt_start  <= 1'b0;
      end else begin
         busy      <= (state_nx != S_IDLE) && (state_nx != S_DONE) && (state_nx != S_ERROR);
         done      <= (state_nx == S_DONE) || (state_nx == S_ERROR);
         cnt_start <= (state_nx == S_MEASURE) && (state != S_MEASURE);
         if (start_acc) begin
            err        <= 1'b0;
            resp_valid <= 1'b0;
         end else begin
            if (state_nx == S_ERROR) begin
               err <= 1'b1;
            end
            if (state_nx == S_DONE) begin
               resp_valid <= 1'b1;
            end
         end
      end
   end

endmodule
